// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: button indices, debounce state encoding and counter width.
package button_conditioner_pkg;
  localparam int NUM_BTNS = 5;
  localparam int BTN_U = 4;
  localparam int BTN_L = 3;
  localparam int BTN_R = 2;
  localparam int BTN_D = 1;
  localparam int BTN_C = 0;
  localparam int CNT_W = 24;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } db_state_e;
endpackage

// File: rtl/button_conditioner_btn_debounce_cell.sv
// btn_debounce_cell: synchronizer, debounce FSM and, with BTN_AUTOREPEAT_EN, auto-repeat for one button.
module btn_debounce_cell
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_PERIOD = 10000000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);
  // The entry cycle of a wait state is already one stable cycle, so the last count is D-2.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_W = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);
  logic [RPT_W-1:0] rcnt_q;
  logic rep_q;
`endif
  logic [1:0] sync_q;
  db_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic level_q, press_q, release_q;
  logic synced;
  assign synced = sync_q[1];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      state_q <= ST_IDLE;
      cnt_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rcnt_q <= '0;
      rep_q <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[0], raw_i};
      press_q <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (synced) begin
          state_q <= ST_PRESS_WAIT;
          cnt_q <= '0;
        end
        ST_PRESS_WAIT: if (!synced) begin
          state_q <= ST_IDLE;
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          state_q <= ST_HELD;
          cnt_q <= '0;
          level_q <= 1'b1;
          press_q <= 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        ST_HELD: if (!synced) begin
          state_q <= ST_RELEASE_WAIT;
          cnt_q <= '0;
        end else begin
          cnt_q <= '0;
`ifdef BTN_AUTOREPEAT_EN
          if (rcnt_q == (rep_q ? RP_LAST : RD_LAST)) begin
            press_q <= 1'b1;
            rcnt_q <= '0;
            rep_q <= 1'b1;
          end else rcnt_q <= rcnt_q + 1'b1;
`endif
        end
        ST_RELEASE_WAIT: if (synced) begin
          state_q <= ST_HELD;
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          state_q <= ST_IDLE;
          cnt_q <= '0;
          level_q <= 1'b0;
          release_q <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          rcnt_q <= '0;
          rep_q <= 1'b0;
`endif
        end else cnt_q <= cnt_q + 1'b1;
      endcase
    end
  end
  assign level_o = level_q;
  assign press_o = press_q;
  assign release_o = release_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: five independent debounced buttons with press/release pulses.
// Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses while a button is held.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic                btn_any
);
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << CNT_W) - 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_conditioner: illegal timing parameters");
  end
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_cell
    btn_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_cell (
      .clk(clk),
      .reset(reset),
      .raw_i(btn_raw[i]),
      .level_o(btn_level[i]),
      .press_o(btn_press[i]),
      .release_o(btn_release[i])
    );
  end
  assign btn_any = |btn_press;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of debounce timing, pulses, reset abort and auto-repeat.
module tb_button_conditioner;
  import button_conditioner_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] btn_raw = '0;
  logic [4:0] btn_level, btn_press, btn_release;
  logic btn_any;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_any(btn_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] lvl, input logic [4:0] prs, input logic [4:0] rel);
    chk({tag, "_level"}, btn_level, lvl);
    chk({tag, "_press"}, btn_press, prs);
    chk({tag, "_release"}, btn_release, rel);
    chk({tag, "_any"}, {4'b0, btn_any}, {4'b0, |prs});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    btn_raw = '0;
    tick();
    tick();
    chk_all("reset", 5'b0, 5'b0, 5'b0);
    reset = 1'b1;
    tick();
    cyc = 0;
  endtask

  initial begin
    // clean press on U, released at cycle 10
    do_reset();
    btn_raw[BTN_U] = 1'b1;
    while (cyc < 18) begin
      tick();
      chk_all("clean", (cyc >= 6 && cyc < 16) ? 5'b10000 : 5'b0,
              cyc == 6 ? 5'b10000 : 5'b0, cyc == 16 ? 5'b10000 : 5'b0);
      if (cyc == 10) btn_raw[BTN_U] = 1'b0;
    end
    // bounce on C: 1,0,1,0 every 2 cycles, final rise at cycle 8
    do_reset();
    btn_raw[BTN_C] = 1'b1;
    while (cyc < 16) begin
      tick();
      chk_all("bounce", cyc >= 14 ? 5'b00001 : 5'b0, cyc == 14 ? 5'b00001 : 5'b0, 5'b0);
      btn_raw[BTN_C] = (cyc >= 8) ? 1'b1 : ((cyc / 2) % 2 == 0);
    end
    // simultaneous U and C, released at cycle 20
    do_reset();
    btn_raw = 5'b10001;
    while (cyc < 28) begin
      tick();
      chk_all("simul", (cyc >= 6 && cyc < 26) ? 5'b10001 : 5'b0,
              cyc == 6 ? 5'b10001 : 5'b0, cyc == 26 ? 5'b10001 : 5'b0);
      if (cyc == 20) btn_raw = 5'b0;
    end
    // reset pulse in the middle of R's press debounce
    do_reset();
    btn_raw[BTN_R] = 1'b1;
    while (cyc < 13) begin
      tick();
      chk_all("rstmid", cyc >= 11 ? 5'b00100 : 5'b0, cyc == 11 ? 5'b00100 : 5'b0, 5'b0);
      if (cyc == 3) reset = 1'b0;
      if (cyc == 5) reset = 1'b1;
    end
    // long hold on L, released at cycle 24
    do_reset();
    btn_raw[BTN_L] = 1'b1;
    while (cyc < 32) begin
      tick();
`ifdef BTN_AUTOREPEAT_EN
      chk_all("repeat", (cyc >= 6 && cyc < 30) ? 5'b01000 : 5'b0,
              (cyc == 6 || cyc == 16 || cyc == 19 || cyc == 22 || cyc == 25) ? 5'b01000 : 5'b0,
              cyc == 30 ? 5'b01000 : 5'b0);
`else
      chk_all("repeat", (cyc >= 6 && cyc < 30) ? 5'b01000 : 5'b0,
              cyc == 6 ? 5'b01000 : 5'b0, cyc == 30 ? 5'b01000 : 5'b0);
`endif
      if (cyc == 24) btn_raw[BTN_L] = 1'b0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, meaning stable-input cycles required before a level change is accepted (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 Parameter REPEAT_DELAY, default 50000000, meaning hold cycles before the first auto-repeat pulse (only used with BTN_AUTOREPEAT_EN).
REQ-003 Parameter REPEAT_PERIOD, default 10000000, meaning cycles between later auto-repeat pulses (only used with BTN_AUTOREPEAT_EN).
REQ-004 clk  input  1  system clock, 100 MHz board clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 btn_raw  input  5  raw, asynchronous push-button levels; bit order [4]=U, [3]=L, [2]=R, [1]=D, [0]=C; 1 = pressed.
REQ-007 btn_level  output  5  debounced button level, same bit order.
REQ-008 btn_press  output  5  one-cycle pulse per accepted press (or auto-repeat), same bit order; feeds the data_input bt_* ports.
REQ-009 btn_release  output  5  one-cycle pulse per accepted release.
REQ-010 btn_any  output  1  OR of btn_press.

Function
REQ-011 Each bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-012 Each button SHALL be handled independently; simultaneous activity on several bits SHALL produce simultaneous, independent pulses.
REQ-013 Each button SHALL run an FSM: IDLE (level 0) -> PRESS_WAIT when synced=1; PRESS_WAIT -> HELD after DEBOUNCE_CYCLES consecutive synced=1 cycles, else back to IDLE on any synced=0; HELD -> RELEASE_WAIT when synced=0; RELEASE_WAIT -> IDLE after DEBOUNCE_CYCLES consecutive synced=0 cycles, else back to HELD on any synced=1.
REQ-014 The debounce counter SHALL clear on every state change and on every return to IDLE or HELD.
REQ-015 btn_level SHALL be 1 exactly in HELD and RELEASE_WAIT.
REQ-016 btn_press SHALL pulse for one cycle in the first cycle of HELD entered from PRESS_WAIT; btn_release SHALL pulse for one cycle in the first cycle of IDLE entered from RELEASE_WAIT.
REQ-017 Latency from a clean raw edge to the btn_level/pulse change SHALL be exactly DEBOUNCE_CYCLES+2 clk cycles.
REQ-018 Glitches shorter than DEBOUNCE_CYCLES synced cycles SHALL produce no level change and no pulse.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 While reset=0, all FSMs SHALL be IDLE, counters and synchronizers 0, and btn_level, btn_press, btn_release, btn_any 0.
REQ-021 Reset asserted mid-debounce or mid-hold SHALL abort without emitting any pulse; after release, a held button SHALL be accepted as a new press after DEBOUNCE_CYCLES+2 cycles.

Configuration
REQ-022 With macro BTN_AUTOREPEAT_EN defined, a button remaining in HELD SHALL emit an extra btn_press pulse REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_PERIOD cycles until HELD is left.
REQ-023 Entering RELEASE_WAIT SHALL freeze the repeat counter; returning to HELD SHALL resume it; entering IDLE SHALL clear it.
REQ-024 Without BTN_AUTOREPEAT_EN, exactly one btn_press pulse SHALL occur per accepted press, and no repeat counters or parameters' logic SHALL be synthesized.

Structure
REQ-025 A shared package SHALL hold the button index constants (BTN_U=4, BTN_L=3, BTN_R=2, BTN_D=1, BTN_C=0), NUM_BTNS=5, the debounce state encoding, and counter width 24.
REQ-026 One sub-module btn_debounce_cell (synchronizer, FSM, counter, optional repeat for a single bit) SHALL be instantiated NUM_BTNS times; button_conditioner adds only btn_any.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-027 Clean press: btn_raw[4] 0->1 at cycle 0, held -> btn_level[4]=1 and btn_press[4]=1 at cycle 6 only; btn_any=1 at cycle 6.
REQ-028 Bounce: btn_raw[0] toggles 1,0,1,0 every 2 cycles, then stays 1 -> single btn_press[0] 6 cycles after the final rise; no earlier pulse.
REQ-029 Simultaneous: btn_raw=5'b10001 at cycle 0, released at cycle 20 -> btn_press=5'b10001 at cycle 6; btn_release=5'b10001 at cycle 26.
REQ-030 Reset mid-debounce: btn_raw[2]=1 at cycle 0, reset=0 at cycles 3-4 -> no pulse before cycle 11; btn_press[2] at cycle 11.
REQ-031 Auto-repeat (macro defined): btn_raw[3] held from cycle 0 -> btn_press[3] at cycles 6, 16, 19, 22; without macro only at cycle 6.
